// File: rtl/ysyx_25040109_lsu.sv
// Load/store unit: captures one execute payload, performs at most one dmem read or
// write, and presents the write-back payload with a valid/ready handshake.
module ysyx_25040109_lsu #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mem_ren,
  input  logic        in_mem_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [31:0] in_result,
  input  logic [4:0]  in_rd,
  input  logic        in_rd_wen,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic        out_err,
  output logic [31:0] dmem_raddr,
  output logic        dmem_ren,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic        dmem_rready,
  output logic [31:0] dmem_waddr,
  output logic [31:0] dmem_wdata,
  output logic [2:0]  dmem_wlen,
  output logic        dmem_wen,
  output logic        dmem_wvalid,
  input  logic        dmem_wready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RREQ  = 3'd1,
    S_RWAIT = 3'd2,
    S_WREQ  = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e      state_q;
  logic        in_ready_q, out_valid_q, out_rd_wen_q, out_err_q;
  logic [31:0] out_result_q, dmem_raddr_q, dmem_waddr_q, dmem_wdata_q;
  logic [4:0]  out_rd_q;
  logic [2:0]  dmem_wlen_q, funct3_q;
  logic        dmem_ren_q, dmem_rready_q, dmem_wen_q, dmem_wvalid_q, rd_wen_q;
  logic        acc_err_s;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = !is_store;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic m;
    case (f3[1:0])
      2'b01:   m = lo[0];
      2'b10:   m = (lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] wlen_code(input logic [2:0] f3);
    logic [2:0] c;
    case (f3[1:0])
      2'b00:   c = 3'b001;
      2'b01:   c = 3'b010;
      default: c = 3'b100;
    endcase
    return c;
  endfunction

  // The memory returns the whole aligned word; pick the lane from the low address bits.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Memory ops with an illegal size or misaligned address never reach dmem.
  always_comb begin
    acc_err_s = 1'b0;
    if (in_mem_ren || in_mem_wen) begin
      acc_err_s = !f3_legal(in_mem_wen, in_funct3) ||
                  (CHECK_ALIGN && misaligned(in_funct3, in_addr[1:0]));
    end else begin
      acc_err_s = 1'b0;
    end
  end

  // Control FSM with every output registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_err_q     <= 1'b0;
      out_result_q  <= 32'h0000_0000;
      out_rd_q      <= 5'd0;
      out_rd_wen_q  <= 1'b0;
      rd_wen_q      <= 1'b0;
      funct3_q      <= 3'b000;
      dmem_raddr_q  <= 32'h0000_0000;
      dmem_ren_q    <= 1'b0;
      dmem_rready_q <= 1'b0;
      dmem_waddr_q  <= 32'h0000_0000;
      dmem_wdata_q  <= 32'h0000_0000;
      dmem_wlen_q   <= 3'b000;
      dmem_wen_q    <= 1'b0;
      dmem_wvalid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            funct3_q   <= in_funct3;
            rd_wen_q   <= in_rd_wen;
            out_rd_q   <= in_rd;
            if (acc_err_s) begin
              out_err_q    <= 1'b1;
              out_result_q <= in_addr;
              out_rd_wen_q <= 1'b0;
              out_valid_q  <= 1'b1;
              state_q      <= S_RESP;
            end else if (in_mem_wen) begin
              dmem_waddr_q  <= in_addr;
              dmem_wdata_q  <= in_wdata;
              dmem_wlen_q   <= wlen_code(in_funct3);
              dmem_wen_q    <= 1'b1;
              dmem_wvalid_q <= 1'b1;
              state_q       <= S_WREQ;
            end else if (in_mem_ren) begin
              dmem_raddr_q <= in_addr;
              dmem_ren_q   <= 1'b1;
              state_q      <= S_RREQ;
            end else begin
              out_result_q <= in_result;
              out_rd_wen_q <= in_rd_wen;
              out_valid_q  <= 1'b1;
              state_q      <= S_RESP;
            end
          end
        end
        S_RREQ: begin
          dmem_ren_q    <= 1'b0;
          dmem_rready_q <= 1'b1;
          state_q       <= S_RWAIT;
        end
        S_RWAIT: begin
          if (dmem_rvalid) begin
            dmem_rready_q <= 1'b0;
            out_result_q  <= load_extend(funct3_q, dmem_raddr_q[1:0], dmem_rdata);
            out_rd_wen_q  <= rd_wen_q;
            out_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end
        end
        S_WREQ: begin
          if (dmem_wready) begin
            dmem_wen_q    <= 1'b0;
            dmem_wvalid_q <= 1'b0;
            out_result_q  <= 32'h0000_0000;
            out_rd_wen_q  <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          in_ready_q    <= 1'b1;
          out_valid_q   <= 1'b0;
          dmem_ren_q    <= 1'b0;
          dmem_rready_q <= 1'b0;
          dmem_wen_q    <= 1'b0;
          dmem_wvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign out_rd_wen  = out_rd_wen_q;
  assign out_err     = out_err_q;
  assign dmem_raddr  = dmem_raddr_q;
  assign dmem_ren    = dmem_ren_q;
  assign dmem_rready = dmem_rready_q;
  assign dmem_waddr  = dmem_waddr_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign dmem_wlen   = dmem_wlen_q;
  assign dmem_wen    = dmem_wen_q;
  assign dmem_wvalid = dmem_wvalid_q;

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Directed table-driven bench for the LSU with a small reactive memory responder,
// plus hand-written backpressure and mid-operation reset sequences.
module tb_ysyx_25040109_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        in_mem_ren = 1'b0, in_mem_wen = 1'b0;
  logic [2:0]  in_funct3 = 3'b000;
  logic [31:0] in_addr = 32'h0, in_wdata = 32'h0, in_result = 32'h0;
  logic [4:0]  in_rd = 5'd0;
  logic        in_rd_wen = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_rd_wen, out_err;
  logic [31:0] dmem_raddr, dmem_rdata = 32'h0;
  logic        dmem_ren, dmem_rvalid = 1'b0, dmem_rready;
  logic [31:0] dmem_waddr, dmem_wdata;
  logic [2:0]  dmem_wlen;
  logic        dmem_wen, dmem_wvalid, dmem_wready = 1'b0;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ysyx_25040109_lsu #(.CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_result(in_result),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_err(out_err),
    .dmem_raddr(dmem_raddr), .dmem_ren(dmem_ren), .dmem_rdata(dmem_rdata),
    .dmem_rvalid(dmem_rvalid), .dmem_rready(dmem_rready),
    .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wlen(dmem_wlen),
    .dmem_wen(dmem_wen), .dmem_wvalid(dmem_wvalid), .dmem_wready(dmem_wready)
  );

  typedef struct {
    logic        ren;
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] res;
    logic        rdwen;
    logic [31:0] word;
    int          dly;
    logic [31:0] exp_res;
    logic        exp_err;
    logic        exp_rdwen;
    int          exp_lat;
    int          exp_ren;
    int          exp_wen;
    logic [2:0]  exp_wlen;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    else passed++;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ren_cnt = 0, wen_cnt = 0, rcnt = 0, wcnt = 0, lat = -1;
    logic [31:0] raddr_seen = 32'h0, waddr_seen = 32'h0, wdata_seen = 32'h0;
    logic [2:0]  wlen_seen = 3'b000;
    logic [4:0]  rd = 5'(idx + 1);
    chk("idle_ready", idx, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_mem_ren = v.ren; in_mem_wen = v.wen; in_funct3 = v.f3;
    in_addr = v.addr; in_wdata = v.wdata; in_result = v.res; in_rd = rd; in_rd_wen = v.rdwen;
    dmem_rdata = v.word;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      if (out_valid) begin
        lat = c;
      end else begin
        if (dmem_ren) begin ren_cnt++; raddr_seen = dmem_raddr; end
        if (dmem_wen) begin
          wen_cnt++; waddr_seen = dmem_waddr; wdata_seen = dmem_wdata; wlen_seen = dmem_wlen;
        end
        dmem_rvalid = dmem_rready && (rcnt >= v.dly);
        if (dmem_rready) rcnt++;
        dmem_wready = dmem_wvalid && (wcnt >= v.dly);
        if (dmem_wvalid) wcnt++;
        @(negedge clk);
      end
    end
    dmem_rvalid = 1'b0; dmem_wready = 1'b0;
    chk("latency", idx, lat, v.exp_lat);
    chk("result", idx, out_result, v.exp_res);
    chk("err", idx, {31'd0, out_err}, {31'd0, v.exp_err});
    chk("rd", idx, {27'd0, out_rd}, {27'd0, rd});
    chk("rd_wen", idx, {31'd0, out_rd_wen}, {31'd0, v.exp_rdwen});
    chk("ren_cycles", idx, ren_cnt, v.exp_ren);
    chk("wen_cycles", idx, wen_cnt, v.exp_wen);
    chk("wlen", idx, {29'd0, wlen_seen}, {29'd0, v.exp_wlen});
    chk("raddr", idx, raddr_seen, (v.exp_ren > 0) ? v.addr : 32'h0);
    if (v.exp_wen > 0) begin
      chk("waddr", idx, waddr_seen, v.addr);
      chk("wdata", idx, wdata_seen, v.wdata);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_valid", idx, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    // ren wen f3 addr wdata res rdwen word dly | exp_res err rdwen lat ren wen wlen
    vecs[0]  = '{1'b1,1'b0,3'b000,32'h80000003,32'h0,32'h0,1'b1,32'h80FF1234,0, 32'hFFFFFF80,1'b0,1'b1,2,1,0,3'b000};
    vecs[1]  = '{1'b1,1'b0,3'b100,32'h80000003,32'h0,32'h0,1'b1,32'h80FF1234,0, 32'h00000080,1'b0,1'b1,2,1,0,3'b000};
    vecs[2]  = '{1'b1,1'b0,3'b001,32'h80000002,32'h0,32'h0,1'b1,32'h8001ABCD,2, 32'hFFFF8001,1'b0,1'b1,4,1,0,3'b000};
    vecs[3]  = '{1'b1,1'b0,3'b101,32'h80000002,32'h0,32'h0,1'b1,32'h8001ABCD,0, 32'h00008001,1'b0,1'b1,2,1,0,3'b000};
    vecs[4]  = '{1'b1,1'b0,3'b010,32'h80000000,32'h0,32'h0,1'b1,32'h8001ABCD,1, 32'h8001ABCD,1'b0,1'b1,3,1,0,3'b000};
    vecs[5]  = '{1'b1,1'b0,3'b000,32'h80000001,32'h0,32'h0,1'b1,32'h80FF1234,0, 32'h00000012,1'b0,1'b1,2,1,0,3'b000};
    vecs[6]  = '{1'b1,1'b0,3'b001,32'h80000000,32'h0,32'h0,1'b1,32'h80FF1234,0, 32'h00001234,1'b0,1'b1,2,1,0,3'b000};
    vecs[7]  = '{1'b0,1'b1,3'b001,32'h80000006,32'h0000BEEF,32'h0,1'b1,32'h0,0, 32'h0,1'b0,1'b0,1,0,1,3'b010};
    vecs[8]  = '{1'b0,1'b1,3'b010,32'h80000008,32'hDEADBEEF,32'h0,1'b1,32'h0,3, 32'h0,1'b0,1'b0,4,0,4,3'b100};
    vecs[9]  = '{1'b0,1'b1,3'b000,32'h80000003,32'h000000AB,32'h0,1'b1,32'h0,0, 32'h0,1'b0,1'b0,1,0,1,3'b001};
    vecs[10] = '{1'b1,1'b0,3'b010,32'h80000002,32'h0,32'h0,1'b1,32'hFFFFFFFF,0, 32'h80000002,1'b1,1'b0,0,0,0,3'b000};
    vecs[11] = '{1'b1,1'b0,3'b001,32'h80000001,32'h0,32'h0,1'b1,32'hFFFFFFFF,0, 32'h80000001,1'b1,1'b0,0,0,0,3'b000};
    vecs[12] = '{1'b1,1'b0,3'b011,32'h80000000,32'h0,32'h0,1'b1,32'hFFFFFFFF,0, 32'h80000000,1'b1,1'b0,0,0,0,3'b000};
    vecs[13] = '{1'b0,1'b1,3'b100,32'h80000004,32'h00000001,32'h0,1'b1,32'h0,0, 32'h80000004,1'b1,1'b0,0,0,0,3'b000};
    vecs[14] = '{1'b0,1'b0,3'b000,32'h80000000,32'h0,32'h12345678,1'b1,32'h0,0, 32'h12345678,1'b0,1'b1,0,0,0,3'b000};
    vecs[15] = '{1'b1,1'b1,3'b010,32'h80000010,32'h11111111,32'h0,1'b1,32'h0,0, 32'h0,1'b0,1'b0,1,0,1,3'b100};
    vecs[16] = '{1'b0,1'b0,3'b000,32'h00000000,32'h0,32'hCAFEF00D,1'b0,32'h0,0, 32'hCAFEF00D,1'b0,1'b0,0,0,0,3'b000};
    vecs[17] = '{1'b0,1'b1,3'b010,32'h80000002,32'h22222222,32'h0,1'b1,32'h0,0, 32'h80000002,1'b1,1'b0,0,0,0,3'b000};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 0, {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", 0, {31'd0, out_valid}, 32'd0);
    chk("rst_out_err", 0, {31'd0, out_err}, 32'd0);
    chk("rst_out_result", 0, out_result, 32'h0);
    chk("rst_out_rd", 0, {27'd0, out_rd}, 32'd0);
    chk("rst_out_rd_wen", 0, {31'd0, out_rd_wen}, 32'd0);
    chk("rst_dmem_ctl", 0, {28'd0, dmem_ren, dmem_rready, dmem_wen, dmem_wvalid}, 32'd0);
    chk("rst_wlen", 0, {29'd0, dmem_wlen}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: payload held while out_ready is low.
    in_valid = 1'b1; in_mem_ren = 1'b0; in_mem_wen = 1'b0; in_funct3 = 3'b000;
    in_result = 32'h12345678; in_rd = 5'd7; in_rd_wen = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_result = 32'h0; in_rd = 5'd0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", c, {31'd0, out_valid}, 32'd1);
      chk("bp_result", c, out_result, 32'h12345678);
      chk("bp_rd", c, {27'd0, out_rd}, 32'd7);
      chk("bp_in_ready", c, {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("bp_ready_same_cycle", 0, {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ready_after", 0, {31'd0, in_ready}, 32'd1);
    chk("bp_valid_after", 0, {31'd0, out_valid}, 32'd0);

    // Reset while waiting for read data; a late response must be ignored.
    in_valid = 1'b1; in_mem_ren = 1'b1; in_funct3 = 3'b010; in_addr = 32'h80000000;
    @(negedge clk);
    in_valid = 1'b0; in_mem_ren = 1'b0;
    chk("mr_rreq_ren", 0, {31'd0, dmem_ren}, 32'd1);
    @(negedge clk);
    chk("mr_rwait_rready", 0, {31'd0, dmem_rready}, 32'd1);
    chk("mr_rwait_ren", 0, {31'd0, dmem_ren}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mr_rready", 0, {31'd0, dmem_rready}, 32'd0);
    chk("mr_out_valid", 0, {31'd0, out_valid}, 32'd0);
    chk("mr_in_ready", 0, {31'd0, in_ready}, 32'd1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5A5A5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mr_late_valid", c, {31'd0, out_valid}, 32'd0);
      chk("mr_late_in_ready", c, {31'd0, in_ready}, 32'd1);
    end
    dmem_rvalid = 1'b0;
    run_vec(100, vecs[14]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ysyx_25040109_lsu.md
Name: ysyx_25040109_lsu

Overview:
- Load/store unit between the execute stage and the data-memory channel (dmem read/write ports of the memory block).
- Accepts one execute result per valv/ready handshake. Issues at most one dmem read or write per op.
- Loads: extracts and sign/zero-extends the returned word. Stores: forwards raw data plus a length code.
- Hands the write-back payload downstream with a valid/ready handshake. Non-memory ops pass through in one extra cycle.

Parameters:
- CHECK_ALIGN, 1, when 1 a misaligned halfword/word access is not issued to memory and is flagged on out_err; when 0 alignment is not checked.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (logic resets on the clk edge where rst==0)
- in_valid  in  1  execute payload valid
- in_ready  out  1  LSU can accept a payload
- in_mem_ren  in  1  op is a load
- in_mem_wen  in  1  op is a store (wins if both set)
- in_funct3  in  3  RISC-V funct3 of load/store
- in_addr  in  32  effective address
- in_wdata  in  32  store data (unshifted)
- in_result  in  32  ALU result for non-memory ops
- in_rd  in  5  destination register
- in_rd_wen  in  1  register write enable
- out_valid  out  1  write-back payload valid
- out_ready  in  1  write-back stage accepts
- out_result  out  32  extended load data, or in_result
- out_rd  out  5  registered in_rd
- out_rd_wen  out  1  registered in_rd_wen; forced 0 when out_err
- out_err  out  1  misaligned or illegal funct3
- dmem_raddr  out  32  read address (in_addr, unaligned)
- dmem_ren  out  1  read request
- dmem_rdata  in  32  full aligned word
- dmem_rvalid  in  1  read data valid
- dmem_rready  out  1  LSU accepts read data
- dmem_waddr  out  32  write address
- dmem_wdata  out  32  raw store data
- dmem_wlen  out  3  001 byte, 010 half, 100 word
- dmem_wen  out  1  write enable
- dmem_wvalid  out  1  write valid
- dmem_wready  in  1  memory accepts write

Behaviour:
- Reset values: IDLE state; in_ready=1; out_valid=0; out_err=0; out_result=0; out_rd=0; out_rd_wen=0; dmem_ren=0; dmem_rready=0; dmem_wen=0; dmem_wvalid=0; dmem_wlen=000.
- Input capture: on in_valid&&in_ready, all in_* fields are latched into a payload register. in_ready=1 only in IDLE.
- Funct3 map: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
  - Other codes, and 1xx on stores, are illegal.
- Error path (taken when CHECK_ALIGN=1 and half with addr[0]=1 or word with addr[1:0]!=0, or illegal funct3): IDLE->RESP with out_err=1, out_result=in_addr, no dmem activity.
- IDLE transitions: store->WREQ, load->RREQ, non-memory->RESP with out_result=in_result.
- RREQ (1 cycle): dmem_ren=1, dmem_raddr=latched addr, dmem_rready=0. Next state RWAIT.
- RWAIT: dmem_ren=0, dmem_rready=1; unbounded wait. dmem_ren never rises again in RWAIT.
  - On dmem_rvalid: select byte/half by addr[1:0] (half by addr[1]), extend, register into out_result, go to RESP.
- WREQ: dmem_wen=dmem_wvalid=1, dmem_wlen per size, wdata/waddr held.
  - Hold until the edge where dmem_wready=1, then deassert and go to RESP with out_result=0, out_rd_wen=0.
- RESP: out_valid=1, outputs stable. On out_ready go to IDLE; in_ready rises the following cycle (no same-cycle bypass).
- Latency: non-memory op accepted at edge N gives out_valid at N+1. Load latency = 2 + memory delay.
- Reset mid-operation (any state): return to IDLE next edge, all requests dropped, out_valid=0. A read response arriving afterwards with dmem_rready=0 is ignored.

Test Plan:
- LB addr 0x80000003, memory word 0x80FF1234 -> out_result 0xFFFFFF80; LBU same -> 0x00000080; dmem_ren high exactly one cycle.
- LH addr 0x80000002, word 0x8001ABCD -> 0xFFFF8001; LHU -> 0x00008001; LW addr 0x80000000 -> full word.
- SH addr 0x80000006 data 0x0000BEEF -> one write cycle, dmem_wlen=010, wdata 0x0000BEEF, out_rd_wen=0.
- LW addr 0x80000002 (CHECK_ALIGN=1) -> out_err=1, out_result=0x80000002, no dmem_ren/dmem_wen ever asserted.
- Non-memory op result 0x12345678 with out_ready held low 5 cycles -> out_valid and payload stable; in_ready=0 until the cycle after out_ready.
- rst=0 asserted in RWAIT -> next cycle IDLE, dmem_rready=0, out_valid=0; later dmem_rvalid ignored.
